// File: rtl/fm_param_pkg.sv
// Shared types and default widths for the FM parameter fetch master.
package fm_param_pkg;

    localparam int unsigned DEF_ADDR_W    = 2;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_NUM_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        SWEEP = 2'd2,
        DRAIN = 2'd3
    } state_e;

    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/fm_rd_pipe.sv
// Read-return delay line: carries {valid, idx} READ_LATENCY cycles and tracks reads in flight.
module fm_rd_pipe #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned IDX_W        = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             tail_valid,
    output logic [IDX_W-1:0] tail_idx,
    output logic             empty_next_c
);

    localparam int unsigned CNT_W = $clog2(READ_LATENCY + 1);

    logic [READ_LATENCY-1:0] vld;
    logic [IDX_W-1:0]        idx [READ_LATENCY];
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        count_nxt_c;

    assign tail_valid = vld[READ_LATENCY-1];
    assign tail_idx   = idx[READ_LATENCY-1];

    // Reads in flight after this edge; zero means the pipe drains on this edge.
    always_comb begin
        count_nxt_c  = count + CNT_W'(in_valid) - CNT_W'(tail_valid);
        empty_next_c = (count_nxt_c == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld   <= '0;
            count <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                idx[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            idx[0] <= in_idx;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
            count <= count_nxt_c;
        end
    end

endmodule

// File: rtl/fm_param_fetch_master.sv
// Avalon-MM master sweeping the parameter memory into a shadow bank, plus byte-enabled write-backs.
// Optional PARAM_CHECKSUM_EN adds a per-sweep modular checksum and a zero-sum flag.
module fm_param_fetch_master
    import fm_param_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned NUM_WORDS    = DEF_NUM_WORDS,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    input  logic                            wr_req,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic [be_width(DATA_W)-1:0]     wr_be,
    output logic                            wr_ack,
    output logic [ADDR_W-1:0]               av_address,
    output logic [be_width(DATA_W)-1:0]     av_byteenable,
    output logic                            av_chipselect,
    output logic                            av_write,
    output logic [DATA_W-1:0]               av_writedata,
    output logic                            av_clken,
    input  logic [DATA_W-1:0]               av_readdata,
    output logic                            word_valid,
    output logic [ADDR_W-1:0]               word_idx,
    output logic [DATA_W-1:0]               word_data,
    output logic [NUM_WORDS*DATA_W-1:0]     params_flat
`ifdef PARAM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]               checksum,
    output logic                            checksum_ok
`endif
);

    localparam int unsigned BE_W  = be_width(DATA_W);
    localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);

    state_e              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic                pend, pend_d;
    logic                busy_d, done_d, ack_d;
    logic                cs_d, write_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [BE_W-1:0]     be_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                wr_issue_c;

    logic                tail_valid;
    logic [ADDR_W-1:0]   tail_idx;
    logic                empty_next_c;

    fm_rd_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .IDX_W        (ADDR_W)
    ) u_rd_pipe (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (av_chipselect & ~av_write),
        .in_idx       (av_address),
        .tail_valid   (tail_valid),
        .tail_idx     (tail_idx),
        .empty_next_c (empty_next_c)
    );

    // Next state and next values of every registered bus/handshake output.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        pend_d     = pend;
        done_d     = 1'b0;
        ack_d      = 1'b0;
        cs_d       = 1'b0;
        write_d    = 1'b0;
        addr_d     = av_address;
        be_d       = {BE_W{1'b1}};
        wdata_d    = av_writedata;
        wr_issue_c = 1'b0;

        unique case (state)
            IDLE: begin
                if (wr_req) begin
                    state_d    = WRITE;
                    pend_d     = start;
                    ack_d      = 1'b1;
                    cs_d       = 1'b1;
                    write_d    = 1'b1;
                    addr_d     = wr_addr;
                    be_d       = wr_be;
                    wdata_d    = wr_data;
                    wr_issue_c = 1'b1;
                end else if (start) begin
                    state_d = SWEEP;
                    cs_d    = 1'b1;
                    addr_d  = '0;
                    cnt_d   = CNT_W'(1);
                end
            end
            WRITE: begin
                pend_d = 1'b0;
                if (pend) begin
                    state_d = SWEEP;
                    cs_d    = 1'b1;
                    addr_d  = '0;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                if (cnt < CNT_W'(NUM_WORDS)) begin
                    cs_d   = 1'b1;
                    addr_d = ADDR_W'(cnt);
                    cnt_d  = cnt + CNT_W'(1);
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (tail_valid && empty_next_c) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            pend          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            wr_ack        <= 1'b0;
            av_address    <= '0;
            av_byteenable <= {BE_W{1'b1}};
            av_chipselect <= 1'b0;
            av_write      <= 1'b0;
            av_writedata  <= '0;
            av_clken      <= 1'b1;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            pend          <= pend_d;
            busy          <= busy_d;
            done          <= done_d;
            wr_ack        <= ack_d;
            av_address    <= addr_d;
            av_byteenable <= be_d;
            av_chipselect <= cs_d;
            av_write      <= write_d;
            av_writedata  <= wdata_d;
            av_clken      <= 1'b1;
        end
    end

    // Shadow bank: write-backs merge per byte lane, read returns replace the whole word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_valid  <= 1'b0;
            word_idx    <= '0;
            word_data   <= '0;
            params_flat <= '0;
        end else begin
            word_valid <= tail_valid;
            if (tail_valid) begin
                word_idx  <= tail_idx;
                word_data <= av_readdata;
            end
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (wr_issue_c && (wr_addr == ADDR_W'(w))) begin
                    for (int b = 0; b < BE_W; b++) begin
                        if (wr_be[b]) begin
                            params_flat[w*DATA_W + b*8 +: 8] <= wr_data[b*8 +: 8];
                        end
                    end
                end
                if (tail_valid && (tail_idx == ADDR_W'(w))) begin
                    params_flat[w*DATA_W +: DATA_W] <= av_readdata;
                end
            end
        end
    end

`ifdef PARAM_CHECKSUM_EN
    logic [DATA_W-1:0] sum_c;

    assign sum_c = checksum + av_readdata;

    // Running sum restarts on every sweep entry; the zero flag is latched on the final word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum    <= '0;
            checksum_ok <= 1'b0;
        end else if ((state_d == SWEEP) && (state != SWEEP)) begin
            checksum    <= '0;
            checksum_ok <= 1'b0;
        end else if (tail_valid) begin
            checksum <= sum_c;
            if (done_d) begin
                checksum_ok <= (sum_c == '0);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fm_param_fetch_master.sv
// Directed bench for fm_param_fetch_master with a single-port, latency-1, clken-gated memory model.
// Define PARAM_CHECKSUM_EN on both RTL and bench to exercise the checksum outputs.
module tb_fm_param_fetch_master;

    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_WORDS = 4;
    localparam int unsigned BE_W      = 4;

    logic                          clk = 1'b0;
    logic                          reset_n = 1'b1;
    logic                          start = 1'b0;
    logic                          busy, done;
    logic                          wr_req = 1'b0;
    logic [ADDR_W-1:0]             wr_addr = '0;
    logic [DATA_W-1:0]             wr_data = '0;
    logic [BE_W-1:0]               wr_be = '0;
    logic                          wr_ack;
    logic [ADDR_W-1:0]             av_address;
    logic [BE_W-1:0]               av_byteenable;
    logic                          av_chipselect, av_write, av_clken;
    logic [DATA_W-1:0]             av_writedata, av_readdata;
    logic                          word_valid;
    logic [ADDR_W-1:0]             word_idx;
    logic [DATA_W-1:0]             word_data;
    logic [NUM_WORDS*DATA_W-1:0]   params_flat;
`ifdef PARAM_CHECKSUM_EN
    logic [DATA_W-1:0]             checksum;
    logic                          checksum_ok;
`endif

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem [NUM_WORDS];
    logic [DATA_W-1:0] preload_data [NUM_WORDS];
    logic              preload = 1'b0;
    logic [DATA_W-1:0] rd_q = '0;

    fm_param_fetch_master dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_be         (wr_be),
        .wr_ack        (wr_ack),
        .av_address    (av_address),
        .av_byteenable (av_byteenable),
        .av_chipselect (av_chipselect),
        .av_write      (av_write),
        .av_writedata  (av_writedata),
        .av_clken      (av_clken),
        .av_readdata   (av_readdata),
        .word_valid    (word_valid),
        .word_idx      (word_idx),
        .word_data     (word_data),
        .params_flat   (params_flat)
`ifdef PARAM_CHECKSUM_EN
        ,
        .checksum      (checksum),
        .checksum_ok   (checksum_ok)
`endif
    );

    always #5 clk = ~clk;

    // Slave model: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NUM_WORDS; i++) mem[i] <= preload_data[i];
        end else if (av_clken) begin
            if (av_chipselect && av_write) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (av_byteenable[b]) mem[av_address][b*8 +: 8] <= av_writedata[b*8 +: 8];
                end
            end
            rd_q <= mem[av_address];
        end
    end
    assign av_readdata = rd_q;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic load_mem(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                            input logic [DATA_W-1:0] w2, input logic [DATA_W-1:0] w3);
        preload_data[0] = w0;
        preload_data[1] = w1;
        preload_data[2] = w2;
        preload_data[3] = w3;
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, wr_ack, word_valid, av_chipselect, av_write} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {busy, done, wr_ack, word_valid, av_chipselect, av_write});
        end
        checks++;
        if (av_clken !== 1'b1) begin
            errors++; $display("FAIL reset_clken: got %b expected 1", av_clken);
        end
        checks++;
        if (av_byteenable !== 4'hF) begin
            errors++; $display("FAIL reset_be: got %h expected f", av_byteenable);
        end
        checks++;
        if ({av_address, av_writedata, word_idx, word_data} !== '0) begin
            errors++; $display("FAIL reset_data: got %h expected 0",
                               {av_address, av_writedata, word_idx, word_data});
        end
        checks++;
        if (params_flat !== '0) begin
            errors++; $display("FAIL reset_params: got %h expected 0", params_flat);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [DATA_W-1:0] w [NUM_WORDS];
        logic exp_busy, exp_cs, exp_wv, exp_done;
        logic [ADDR_W-1:0] exp_addr;
        w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        load_mem(w[0], w[1], w[2], w[3]);
        start = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            exp_busy = (cyc <= 5);
            exp_cs   = (cyc <= 4);
            exp_addr = (cyc <= 4) ? ADDR_W'(cyc - 1) : ADDR_W'(3);
            exp_wv   = (cyc >= 3) && (cyc <= 6);
            exp_done = (cyc == 6);
            checks++;
            if ({busy, av_chipselect, av_write, done} !== {exp_busy, exp_cs, 1'b0, exp_done}) begin
                errors++;
                $display("FAIL sweep_ctrl cyc%0d: got %b expected %b", cyc,
                         {busy, av_chipselect, av_write, done}, {exp_busy, exp_cs, 1'b0, exp_done});
            end
            checks++;
            if (av_address !== exp_addr) begin
                errors++; $display("FAIL sweep_addr cyc%0d: got %0d expected %0d", cyc, av_address, exp_addr);
            end
            checks++;
            if (word_valid !== exp_wv) begin
                errors++; $display("FAIL sweep_wv cyc%0d: got %b expected %b", cyc, word_valid, exp_wv);
            end
            if (exp_wv) begin
                checks++;
                if ({word_idx, word_data} !== {ADDR_W'(cyc - 3), w[cyc-3]}) begin
                    errors++;
                    $display("FAIL sweep_word cyc%0d: got %0d/%h expected %0d/%h", cyc,
                             word_idx, word_data, cyc - 3, w[cyc-3]);
                end
            end
        end
        checks++;
        if (params_flat !== {w[3], w[2], w[1], w[0]}) begin
            errors++; $display("FAIL sweep_params: got %h expected %h", params_flat, {w[3], w[2], w[1], w[0]});
        end
    endtask

    task automatic test_write_idle();
        wr_req  = 1'b1;
        wr_addr = 2'd2;
        wr_data = 32'hAABBCCDD;
        wr_be   = 4'b0101;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            checks++;
            if ({wr_ack, av_write, av_chipselect, busy} !== {4{cyc == 1}}) begin
                errors++;
                $display("FAIL wr_ctrl cyc%0d: got %b expected %b", cyc,
                         {wr_ack, av_write, av_chipselect, busy}, {4{cyc == 1}});
            end
            if (cyc == 1) begin
                checks++;
                if ({av_address, av_byteenable, av_writedata} !== {2'd2, 4'b0101, 32'hAABBCCDD}) begin
                    errors++;
                    $display("FAIL wr_bus: got %0d/%b/%h expected 2/0101/aabbccdd",
                             av_address, av_byteenable, av_writedata);
                end
                checks++;
                if (params_flat[2*DATA_W +: DATA_W] !== 32'h33BB33DD) begin
                    errors++; $display("FAIL wr_params: got %h expected 33bb33dd", params_flat[2*DATA_W +: DATA_W]);
                end
            end
            if (wr_ack) wr_req = 1'b0;
        end
        wr_req = 1'b0;
        checks++;
        if (mem[2] !== 32'h33BB33DD) begin
            errors++; $display("FAIL wr_mem: got %h expected 33bb33dd", mem[2]);
        end
        checks++;
        if (av_byteenable !== 4'hF) begin
            errors++; $display("FAIL wr_be_restore: got %b expected 1111", av_byteenable);
        end
    endtask

    task automatic test_start_and_write();
        logic [DATA_W-1:0] w [NUM_WORDS];
        logic exp_wv;
        w = '{32'h55555555, 32'h22222222, 32'h33BB33DD, 32'h44444444};
        start   = 1'b1;
        wr_req  = 1'b1;
        wr_addr = 2'd0;
        wr_data = 32'h55555555;
        wr_be   = 4'hF;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (wr_ack) wr_req = 1'b0;
            exp_wv = (cyc >= 4) && (cyc <= 7);
            checks++;
            if ({wr_ack, av_write, av_chipselect, busy, done} !==
                {cyc == 1, cyc == 1, cyc <= 5, cyc <= 6, cyc == 7}) begin
                errors++;
                $display("FAIL sw_ctrl cyc%0d: got %b expected %b", cyc,
                         {wr_ack, av_write, av_chipselect, busy, done},
                         {cyc == 1, cyc == 1, cyc <= 5, cyc <= 6, cyc == 7});
            end
            if (cyc >= 2 && cyc <= 5) begin
                checks++;
                if (av_address !== ADDR_W'(cyc - 2)) begin
                    errors++; $display("FAIL sw_addr cyc%0d: got %0d expected %0d", cyc, av_address, cyc - 2);
                end
            end
            checks++;
            if (word_valid !== exp_wv) begin
                errors++; $display("FAIL sw_wv cyc%0d: got %b expected %b", cyc, word_valid, exp_wv);
            end
            if (exp_wv) begin
                checks++;
                if ({word_idx, word_data} !== {ADDR_W'(cyc - 4), w[cyc-4]}) begin
                    errors++;
                    $display("FAIL sw_word cyc%0d: got %0d/%h expected %0d/%h", cyc,
                             word_idx, word_data, cyc - 4, w[cyc-4]);
                end
            end
        end
        wr_req = 1'b0;
        checks++;
        if (params_flat !== {w[3], w[2], w[1], w[0]}) begin
            errors++; $display("FAIL sw_params: got %h expected %h", params_flat, {w[3], w[2], w[1], w[0]});
        end
    endtask

    task automatic test_write_during_sweep();
        logic [DATA_W-1:0] w [NUM_WORDS];
        w = '{32'h55555555, 32'h22222222, 32'h33BB33DD, 32'h44444444};
        start = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 2) begin
                wr_req  = 1'b1;
                wr_addr = 2'd1;
                wr_data = 32'hCAFEF00D;
                wr_be   = 4'hF;
            end
            checks++;
            if ({wr_ack, av_write, done} !== {cyc == 7, cyc == 7, cyc == 6}) begin
                errors++;
                $display("FAIL ws_ctrl cyc%0d: got %b expected %b", cyc,
                         {wr_ack, av_write, done}, {cyc == 7, cyc == 7, cyc == 6});
            end
            if (cyc >= 3 && cyc <= 6) begin
                checks++;
                if ({word_valid, word_data} !== {1'b1, w[cyc-3]}) begin
                    errors++;
                    $display("FAIL ws_word cyc%0d: got %b/%h expected 1/%h", cyc, word_valid, word_data, w[cyc-3]);
                end
            end
            if (cyc == 7) begin
                checks++;
                if (av_address !== 2'd1) begin
                    errors++; $display("FAIL ws_addr: got %0d expected 1", av_address);
                end
            end
            if (wr_ack) wr_req = 1'b0;
        end
        wr_req = 1'b0;
        checks++;
        if (mem[1] !== 32'hCAFEF00D || params_flat[DATA_W +: DATA_W] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL ws_result: got mem %h params %h expected cafef00d", mem[1], params_flat[DATA_W +: DATA_W]);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n_done;
        logic [DATA_W-1:0] w [NUM_WORDS];
        w = '{32'h55555555, 32'hCAFEF00D, 32'h33BB33DD, 32'h44444444};
        start = 1'b1;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if ({busy, word_valid} !== 2'b11) begin
            errors++; $display("FAIL rm_pre: got %b expected 11", {busy, word_valid});
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, word_valid, av_chipselect, av_clken, av_byteenable} !== {4'b0000, 1'b1, 4'hF}) begin
            errors++;
            $display("FAIL rm_async: got %b expected 000011111",
                     {busy, done, word_valid, av_chipselect, av_clken, av_byteenable});
        end
        checks++;
        if (params_flat !== '0) begin
            errors++; $display("FAIL rm_params: got %h expected 0", params_flat);
        end
        @(negedge clk);
        reset_n = 1'b1;
        n_done = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (done || wr_ack || busy) n_done++;
        end
        checks++;
        if (n_done !== 0) begin
            errors++; $display("FAIL rm_quiet: got %0d activity cycles expected 0", n_done);
        end
        start = 1'b1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (done !== (cyc == 6)) begin
                errors++; $display("FAIL rm_done cyc%0d: got %b expected %b", cyc, done, cyc == 6);
            end
        end
        checks++;
        if (params_flat !== {w[3], w[2], w[1], w[0]}) begin
            errors++; $display("FAIL rm_params_after: got %h expected %h", params_flat, {w[3], w[2], w[1], w[0]});
        end
    endtask

`ifdef PARAM_CHECKSUM_EN
    task automatic test_checksum();
        load_mem(32'h00000001, 32'hFFFFFFFF, 32'h00000010, 32'hFFFFFFF0);
        start = 1'b1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 5) begin
                checks++;
                if ({checksum, checksum_ok} !== {32'h00000010, 1'b0}) begin
                    errors++; $display("FAIL cs_mid: got %h/%b expected 00000010/0", checksum, checksum_ok);
                end
            end
            if (cyc >= 6) begin
                checks++;
                if ({checksum, checksum_ok} !== {32'h0, 1'b1}) begin
                    errors++; $display("FAIL cs_final cyc%0d: got %h/%b expected 0/1", cyc, checksum, checksum_ok);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sweep();
        test_write_idle();
        test_start_and_write();
        test_write_during_sweep();
        test_reset_mid_sweep();
`ifdef PARAM_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
